// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier:
// FSM states, recode encodings and operand extension.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    REC_ZERO = 3'd0,
    REC_P1   = 3'd1,
    REC_P2   = 3'd2,
    REC_M1   = 3'd3,
    REC_M2   = 3'd4
  } rec_t;

  localparam int MAX_EXT = 64;

  // Extends the low w bits of value to MAX_EXT bits, sign or zero per sgn.
  function automatic logic [MAX_EXT-1:0] width_ext(input logic [MAX_EXT-1:0] value,
                                                    input int unsigned w,
                                                    input logic sgn);
    logic [MAX_EXT-1:0] mask;
    logic               top;
    mask = {MAX_EXT{1'b1}} << w;
    top  = |(value & (64'd1 << (w - 1)));
    if (sgn && top) width_ext = value | mask;
    else            width_ext = value & ~mask;
  endfunction

endpackage

// File: rtl/booth_mult_r4_if.sv
// Start/busy/done request bus of the Booth multiplier.
interface booth_mult_r4_if #(parameter int WIDTH = 8);
  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 signed_mode;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   prod;

  modport master (output start, multiplicand, multiplier, signed_mode,
                  input  busy, done, prod);
  modport slave  (input  start, multiplicand, multiplier, signed_mode,
                  output busy, done, prod);
endinterface

// File: rtl/booth_r4_pp_sel.sv
// Radix-4 Booth partial-product selector: maps {Q1,Q0,Q_1} to an addend
// and carry-in so that negative multiples are formed as ~x + 1.
module booth_r4_pp_sel
  import booth_pkg::*;
#(
  parameter int NX = 12
) (
  input  logic [2:0]    i_triplet,
  input  logic [NX-1:0] i_mx,
  output logic [NX-1:0] o_addend,
  output logic          o_cin
);

  rec_t w_rec;

  always_comb begin
    w_rec = REC_ZERO;
    case (i_triplet)
      3'b001, 3'b010: w_rec = REC_P1;
      3'b011:         w_rec = REC_P2;
      3'b100:         w_rec = REC_M2;
      3'b101, 3'b110: w_rec = REC_M1;
      default:        w_rec = REC_ZERO;
    endcase
  end

  always_comb begin
    o_addend = '0;
    o_cin    = 1'b0;
    case (w_rec)
      REC_P1: o_addend = i_mx;
      REC_P2: o_addend = {i_mx[NX-2:0], 1'b0};
      REC_M1: begin
        o_addend = ~i_mx;
        o_cin    = 1'b1;
      end
      REC_M2: begin
        o_addend = ~{i_mx[NX-2:0], 1'b0};
        o_cin    = 1'b1;
      end
      default: o_addend = '0;
    endcase
  end

endmodule

// File: rtl/booth_mult_r4.sv
// Sequential radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or
// unsigned per operation, ITER cycles of iteration followed by a done strobe.
module booth_mult_r4
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  booth_mult_r4_if.slave  bus
);

  // Operands are widened by two bits so unsigned values stay positive.
  localparam int N    = WIDTH + 2;
  localparam int NX   = N + 2;
  localparam int ITER = N / 2;
  localparam int CW   = $clog2(ITER + 1);
  localparam int PW   = 2 * WIDTH;

  state_t          r_state, w_state_next;
  logic [NX-1:0]   r_acc, r_mx;
  logic [N-1:0]    r_q;
  logic            r_q1;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_prod;

  logic            w_accept, w_last, w_busy, w_done, w_cin;
  logic [NX-1:0]   w_addend, w_sum, w_acc_next;
  logic [NX+N:0]   w_shift;
  logic [N-1:0]    w_q_next;
  logic            w_q1_next;

  assign w_accept = bus.start && (r_state != RUN);
  assign w_last   = (r_cnt == CW'(ITER - 1));

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: if (bus.start) w_state_next = RUN;
      RUN: begin
        w_busy = 1'b1;
        if (w_last) w_state_next = FIN;
      end
      FIN: begin
        w_done       = 1'b1;
        w_state_next = bus.start ? RUN : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  booth_r4_pp_sel #(.NX(NX)) u_pp_sel (
    .i_triplet ({r_q[1:0], r_q1}),
    .i_mx      (r_mx),
    .o_addend  (w_addend),
    .o_cin     (w_cin)
  );

  assign w_sum      = r_acc + w_addend + NX'(w_cin);
  assign w_shift    = $signed({w_sum, r_q, r_q1}) >>> 2;
  assign w_acc_next = w_shift[NX+N:N+1];
  assign w_q_next   = w_shift[N:1];
  assign w_q1_next  = w_shift[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_mx    <= '0;
      r_q     <= '0;
      r_q1    <= 1'b0;
      r_cnt   <= '0;
      r_prod  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_mx  <= NX'(width_ext(MAX_EXT'(bus.multiplicand), WIDTH, bus.signed_mode));
        r_q   <= N'(width_ext(MAX_EXT'(bus.multiplier), WIDTH, bus.signed_mode));
        r_acc <= '0;
        r_q1  <= 1'b0;
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        r_acc <= w_acc_next;
        r_q   <= w_q_next;
        r_q1  <= w_q1_next;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) r_prod <= PW'({w_acc_next[N-1:0], w_q_next});
      end
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.prod = r_prod;

endmodule

// File: tb/tb_booth_mult_r4.sv
// Directed and randomised checks of booth_mult_r4 at WIDTH=8 and WIDTH=16.
module tb_booth_mult_r4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  booth_mult_r4_if #(.WIDTH(8))  if8();
  booth_mult_r4_if #(.WIDTH(16)) if16();

  booth_mult_r4 #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
  booth_mult_r4 #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));

  int n_assert = 0;
  int n_fail   = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic run8(input logic [7:0] m, input logic [7:0] q, input logic sm,
                      input logic [15:0] expv, input string tag);
    logic [15:0] prev;
    int cyc;
    prev = if8.prod;
    if8.multiplicand = m;
    if8.multiplier   = q;
    if8.signed_mode  = sm;
    if8.start        = 1'b1;
    tick;
    if8.start = 1'b0;
    cyc = 0;
    while (if8.busy === 1'b1 && cyc < 40) begin
      check({tag, " hold"}, 32'(if8.prod), 32'(prev));
      cyc++;
      tick;
    end
    check({tag, " latency"}, 32'(cyc), 32'd5);
    check({tag, " done"}, 32'(if8.done), 32'd1);
    check({tag, " prod"}, 32'(if8.prod), 32'(expv));
    $display("w8  sm=%0d M=%h Q=%h prod=%h exp=%h cyc=%0d", sm, m, q, if8.prod, expv, cyc);
    tick;
    check({tag, " done_clr"}, 32'(if8.done), 32'd0);
  endtask

  task automatic run16(input logic [15:0] m, input logic [15:0] q, input logic sm,
                       input logic [31:0] expv, input string tag);
    int cyc;
    if16.multiplicand = m;
    if16.multiplier   = q;
    if16.signed_mode  = sm;
    if16.start        = 1'b1;
    tick;
    if16.start = 1'b0;
    cyc = 0;
    while (if16.busy === 1'b1 && cyc < 40) begin
      cyc++;
      tick;
    end
    check({tag, " latency"}, 32'(cyc), 32'd9);
    check({tag, " done"}, 32'(if16.done), 32'd1);
    check({tag, " prod"}, if16.prod, expv);
    $display("w16 sm=%0d M=%h Q=%h prod=%h exp=%h cyc=%0d", sm, m, q, if16.prod, expv, cyc);
  endtask

  initial begin
    int cyc;
    logic [15:0] m16, q16;
    logic        sm16;
    longint      a, b, p;

    rst = 1'b1;
    if8.start = 1'b0;  if8.multiplicand = '0;  if8.multiplier = '0;  if8.signed_mode = 1'b0;
    if16.start = 1'b0; if16.multiplicand = '0; if16.multiplier = '0; if16.signed_mode = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    check("rst busy", 32'(if8.busy), 32'd0);
    check("rst done", 32'(if8.done), 32'd0);
    check("rst prod", 32'(if8.prod), 32'd0);
    check("rst prod16", if16.prod, 32'd0);
    tick;

    // Basic signed product and hold in idle
    run8(8'd7, 8'hFD, 1'b1, 16'hFFEB, "s7xm3");
    for (int i = 0; i < 10; i++) begin
      check("idle hold", 32'(if8.prod), 32'h0000FFEB);
      tick;
    end

    // Extremes
    run8(8'h80, 8'h80, 1'b1, 16'h4000, "smin_sq");
    run8(8'h80, 8'h7F, 1'b1, 16'hC080, "smin_smax");
    run8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "umax_sq");
    run8(8'hFF, 8'h00, 1'b0, 16'h0000, "umax_zero");
    run8(8'hFF, 8'hFF, 1'b1, 16'h0001, "sm1_sq");

    // start held high; operand changes during RUN are ignored
    if8.multiplicand = 8'd3;
    if8.multiplier   = 8'd4;
    if8.signed_mode  = 1'b1;
    if8.start        = 1'b1;
    tick;
    check("b2b busy", 32'(if8.busy), 32'd1);
    if8.multiplicand = 8'd5;
    if8.multiplier   = 8'd6;
    cyc = 0;
    while (if8.done !== 1'b1 && cyc < 40) begin
      cyc++;
      tick;
    end
    check("b2b lat1", 32'(cyc), 32'd5);
    check("b2b prod1", 32'(if8.prod), 32'h0000000C);
    $display("w8  b2b first prod=%h", if8.prod);
    tick;
    if8.start = 1'b0;
    check("b2b done_lo", 32'(if8.done), 32'd0);
    check("b2b busy2", 32'(if8.busy), 32'd1);
    check("b2b hold", 32'(if8.prod), 32'h0000000C);
    cyc = 1;
    while (if8.done !== 1'b1 && cyc < 40) begin
      cyc++;
      tick;
    end
    check("b2b gap", 32'(cyc), 32'd6);
    check("b2b prod2", 32'(if8.prod), 32'h0000001E);
    $display("w8  b2b second prod=%h gap=%0d", if8.prod, cyc);
    tick;
    check("b2b idle_done", 32'(if8.done), 32'd0);
    check("b2b idle_busy", 32'(if8.busy), 32'd0);

    // Reset during the third RUN cycle aborts
    if8.multiplicand = 8'd9;
    if8.multiplier   = 8'd9;
    if8.signed_mode  = 1'b1;
    if8.start        = 1'b1;
    tick;
    if8.start = 1'b0;
    tick;
    tick;
    check("abort pre_busy", 32'(if8.busy), 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("abort busy", 32'(if8.busy), 32'd0);
    check("abort done", 32'(if8.done), 32'd0);
    check("abort prod", 32'(if8.prod), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("abort no_done", 32'(if8.done), 32'd0);
      tick;
    end
    run8(8'd5, 8'd5, 1'b1, 16'h0019, "post_rst");

    // 16-bit corners then random pairs
    run16(16'h8000, 16'h8000, 1'b1, 32'h40000000, "w16 smin_sq");
    run16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "w16 umax_sq");
    run16(16'h8000, 16'h7FFF, 1'b1, 32'hC0008000, "w16 smin_smax");
    for (int i = 0; i < 2000; i++) begin
      m16  = 16'($urandom);
      q16  = 16'($urandom);
      sm16 = 1'($urandom_range(0, 1));
      a = sm16 ? longint'($signed(m16)) : longint'(m16);
      b = sm16 ? longint'($signed(q16)) : longint'(q16);
      p = a * b;
      run16(m16, q16, sm16, p[31:0], "w16 rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_mult_r4.md
Name: booth_mult_r4

Overview:
Parametrised radix-4 Booth sequential multiplier. It is the next generation of the team's 8-bit radix-2 Booth unit. It adds the following:
- configurable operand width;
- a per-operation signed/unsigned mode;
- half the iteration count;
- a registered result that stays stable between operations;
- a one-cycle done strobe.

It sits beside the ALU as a multi-cycle arithmetic resource driven by a start/busy/done handshake.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 4.
ITER, WIDTH/2+1, derived localparam, not overridable; number of radix-4 iterations, computed as N/2 where N = WIDTH+2 is the internal extended width.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
multiplicand  input  WIDTH  operand M; captured on accepted start
multiplier  input  WIDTH  operand Q; captured on accepted start
signed_mode  input  1  1 = both operands two's complement, 0 = both unsigned; captured on accepted start
busy  output  1  high while iterating
done  output  1  one-cycle pulse when prod is updated
prod  output  2*WIDTH  registered product; held until the next completion

Behaviour:
- Reset (one clock; reset synchronous, active-high):
  - rst=1 at an edge forces: state IDLE, busy=0, done=0, prod=0, iteration counter=0.
  - Reset takes priority over start.
  - Reset mid-operation aborts the operation; no done pulse is produced.
- States:
  - IDLE -> RUN on an accepted start.
  - RUN -> FIN when the ITER-th iteration is performed.
  - FIN -> RUN if start=1 in FIN (back-to-back operation).
  - FIN -> IDLE otherwise.
- Outputs by state:
  - busy = (state==RUN).
  - done = (state==FIN); FIN lasts exactly one cycle.
- Start acceptance:
  - Accepted when start=1 and busy=0, i.e. in IDLE or FIN.
  - start while busy=1 is ignored; operands are not re-captured.
- Load (edge k, start accepted):
  - Mx = multiplicand extended to N bits; Qx = multiplier extended to N bits.
  - Extension is sign extension when signed_mode=1, zero extension when 0.
  - ACC (N+2 bits) = 0; Q_1 = 0; counter = 0.
  - Mx is additionally sign-extended to N+2 bits for ACC arithmetic.
- Iteration (edges k+1 .. k+ITER):
  - Recode the triplet {Q[1],Q[0],Q_1}:
    - 000 / 111 -> 0
    - 001 / 010 -> +M
    - 011 -> +2M
    - 100 -> -2M
    - 101 / 110 -> -M
  - Add the selected value to ACC modulo 2^(N+2). -M and -2M are formed as the inverted operand plus carry-in 1.
  - Arithmetically shift {ACC,Q,Q_1} right by 2, replicating ACC's MSB.
  - Increment the counter.
- Completion:
  - At edge k+ITER: prod <= low 2*WIDTH bits of {ACC[N-1:0],Q} as computed by the final iteration; state -> FIN.
  - Timing: busy is high for ITER cycles after the load edge. done is high in the cycle after edge k+ITER. prod is valid from that cycle onward.
  - prod holds its previous value throughout RUN.
- Width rules:
  - The result is exact for all operand pairs in both modes; no overflow indication is needed.
  - In signed mode, prod is two's complement; in unsigned mode, prod is an unsigned magnitude.
- Back-to-back: start=1 during FIN loads new operands at that edge. done is low in the next cycle, and busy is high again.

Decomposition:
- Package booth_pkg:
  - state enum: IDLE, RUN, FIN;
  - 3-bit recode encodings: REC_ZERO, REC_P1, REC_P2, REC_M1, REC_M2;
  - function width_ext(value, signed_mode).
- One combinational sub-module, booth_r4_pp_sel:
  - inputs: triplet, Mx;
  - outputs: N+2-bit addend and carry-in.
  - The parent holds the FSM, registers, adder and shifter.

Test Plan:
1. WIDTH=8, signed_mode=1, M=7, Q=-3 (0xFD) -> busy high 5 cycles; done pulse; prod=0xFFEB (-21); prod held at 0xFFEB for 10 idle cycles.
2. WIDTH=8, signed, M=0x80, Q=0x80 -> prod=0x4000. Also signed M=0x80, Q=0x7F -> prod=0xC080.
3. WIDTH=8, unsigned, M=0xFF, Q=0xFF -> prod=0xFE01. Also unsigned M=0xFF, Q=0x00 -> prod=0x0000.
4. start held high across an operation with operands changed mid-run -> the first result uses the originally captured operands. A new op loads in the FIN cycle, done pulses again 6 cycles after the first done.
5. rst=1 at the 3rd RUN cycle -> next cycle busy=0, done=0, prod=0; no done pulse. A following start of 5*5 gives prod=0x0019.
6. WIDTH=16, 2000 random signed and unsigned pairs vs a reference model -> all prod match; every result has latency ITER=9 cycles from the load edge to done.
